// File: rtl/id_ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared constants for the decode/issue stage:
//   - ALU_* operation codes understood by the execute-stage ALU (5 bits)
//   - RV32I major opcodes (OPC_*) and funct3/funct7 values used by decode
//   - shamt_ext(): zero-extends a 5-bit shift amount to a full operand
// ----------------------------------------------------------------------------
package id_ex_stage_pkg;

    // ALU operation select
    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;  // SUB / SRA / SRAI

    // The ALU shifts by the whole of op2, so shift amounts are zero-extended
    function automatic logic [31:0] shamt_ext(input logic [4:0] shamt);
        return {27'b0, shamt};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the fetch-side handshake, register-file read port, flush and the
// execute-side handshake/operands of the decode/issue stage.
//   slave  : the id_ex_stage view
//   master : the surrounding pipeline (fetch, register file, execute)
// ----------------------------------------------------------------------------
interface id_ex_stage_if;

    // fetch side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    // register-file read port
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    // control
    logic        flush;
    // execute side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [4:0]  ex_alu_sel;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic [31:0] ex_pc;
    logic        ex_illegal;

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid,
               ex_op1, ex_op2, ex_alu_sel, ex_rd, ex_we, ex_pc, ex_illegal
    );

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid,
               ex_op1, ex_op2, ex_alu_sel, ex_rd, ex_we, ex_pc, ex_illegal
    );

endinterface

// File: rtl/id_ex_stage_imm_gen.sv
// ----------------------------------------------------------------------------
// id_ex_stage_imm_gen
// Combinational RV32I immediate generator.
//   instr  in  [31:7]  instruction word (opcode bits are not needed)
//   imm_i  out 32      sign-extended I-immediate
//   imm_s  out 32      sign-extended S-immediate
//   imm_u  out 32      U-immediate, already shifted into bits [31:12]
// ----------------------------------------------------------------------------
module id_ex_stage_imm_gen (
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_u
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u = {instr[31:12], 12'b0};

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// Decode-and-issue stage: decodes an RV32I instruction, reads the register
// file combinationally and registers ALU operands, ALU select and writeback
// control into the ID/EX pipeline register.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    id_ex_stage_if.slave: fetch handshake (in_valid/in_ready/instr/pc),
//          register-file port (rs*_addr/rs*_data), flush, execute handshake
//          (out_valid/out_ready) and the ex_* issue outputs
// Parameter RESET_PC_TAG is shown on ex_pc whenever no instruction is held.
// ----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    id_ex_stage_if.slave   bus
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;

    logic [31:0] dec_op1;
    logic [31:0] dec_op2;
    logic [4:0]  dec_sel;
    logic        dec_wb;       // opcode class writes a register
    logic        dec_illegal;
    logic        dec_we;

    logic        out_valid_q, out_valid_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [4:0]  alu_sel_q, alu_sel_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic [31:0] pc_q, pc_d;
    logic        illegal_q, illegal_d;

    logic        in_ready;
    logic        capture;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];
    assign rd     = bus.instr[11:7];

    assign bus.rs1_addr = bus.instr[19:15];
    assign bus.rs2_addr = bus.instr[24:20];

    id_ex_stage_imm_gen u_imm_gen (
        .instr (bus.instr[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_u (imm_u)
    );

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        dec_op1     = bus.rs1_data;
        dec_op2     = bus.rs2_data;
        dec_sel     = ALU_NONE;
        dec_wb      = 1'b0;
        dec_illegal = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec_wb = 1'b1;
                case (funct3)
                    F3_ADD: begin
                        dec_sel = ALU_ADD;
                        if (funct7 == F7_ALT) begin
                            // SUB: the ALU only adds, so negate op2 here
                            dec_op2 = ~bus.rs2_data + 32'd1;
                        end else if (funct7 != F7_BASE) begin
                            dec_illegal = 1'b1;
                        end
                    end
                    F3_SLL: begin
                        dec_sel     = ALU_SLL;
                        dec_op2     = shamt_ext(bus.rs2_data[4:0]);
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    F3_SR: begin
                        dec_sel     = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec_op2     = shamt_ext(bus.rs2_data[4:0]);
                        dec_illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                    F3_SLT: begin
                        dec_sel     = ALU_SLT;
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    F3_SLTU: begin
                        dec_sel     = ALU_SLTU;
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    F3_XOR: begin
                        dec_sel     = ALU_XOR;
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    F3_OR: begin
                        dec_sel     = ALU_OR;
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    default: begin
                        dec_sel     = ALU_AND;
                        dec_illegal = (funct7 != F7_BASE);
                    end
                endcase
            end

            OPC_OP_IMM: begin
                dec_wb  = 1'b1;
                dec_op2 = imm_i;
                case (funct3)
                    F3_ADD:  dec_sel = ALU_ADD;
                    F3_SLT:  dec_sel = ALU_SLT;
                    F3_SLTU: dec_sel = ALU_SLTU;
                    F3_XOR:  dec_sel = ALU_XOR;
                    F3_OR:   dec_sel = ALU_OR;
                    F3_AND:  dec_sel = ALU_AND;
                    F3_SLL: begin
                        dec_sel     = ALU_SLL;
                        dec_op2     = shamt_ext(bus.instr[24:20]);
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    default: begin  // SRLI / SRAI
                        dec_sel     = bus.instr[30] ? ALU_SRA : ALU_SRL;
                        dec_op2     = shamt_ext(bus.instr[24:20]);
                        dec_illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end

            OPC_LUI: begin
                // ALU_LUI performs the 12-bit left shift itself
                dec_sel = ALU_LUI;
                dec_op1 = {12'b0, bus.instr[31:12]};
                dec_op2 = imm_u;
                dec_wb  = 1'b1;
            end

            OPC_AUIPC: begin
                dec_sel = ALU_ADD;
                dec_op1 = bus.pc;
                dec_op2 = imm_u;
                dec_wb  = 1'b1;
            end

            OPC_JAL, OPC_JALR: begin
                // link value pc + 4
                dec_sel = ALU_ADD;
                dec_op1 = bus.pc;
                dec_op2 = 32'd4;
                dec_wb  = 1'b1;
            end

            OPC_LOAD: begin
                dec_sel = ALU_ADD;
                dec_op2 = imm_i;
                dec_wb  = 1'b1;
            end

            OPC_STORE: begin
                dec_sel = ALU_ADD;
                dec_op2 = imm_s;
            end

            OPC_BRANCH: begin
                dec_sel = ALU_NONE;
            end

            OPC_FENCE, OPC_SYSTEM: begin
                dec_sel = ALU_NONE;
                dec_op2 = imm_i;
            end

            default: begin
                dec_sel     = ALU_NONE;
                dec_illegal = 1'b1;
            end
        endcase

        // Illegal instructions still issue, but ask the ALU for nothing
        if (dec_illegal) begin
            dec_sel = ALU_NONE;
        end
    end

    assign dec_we = dec_wb && (rd != 5'd0) && !dec_illegal;

    // ------------------------------------------------------------------
    // Handshake and ID/EX register
    // ------------------------------------------------------------------
    assign in_ready = !out_valid_q || bus.out_ready;
    assign capture  = bus.in_valid && in_ready && !bus.flush;

    always_comb begin
        out_valid_d = out_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        alu_sel_d   = alu_sel_q;
        rd_d        = rd_q;
        we_d        = we_q;
        pc_d        = pc_q;
        illegal_d   = illegal_q;

        if (bus.flush) begin
            // kills both the held instruction and anything presented now
            out_valid_d = 1'b0;
            we_d        = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            op1_d       = dec_op1;
            op2_d       = dec_op2;
            alu_sel_d   = dec_sel;
            rd_d        = rd;
            we_d        = dec_we;
            pc_d        = bus.pc;
            illegal_d   = dec_illegal;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            alu_sel_q   <= ALU_NONE;
            rd_q        <= 5'd0;
            we_q        <= 1'b0;
            pc_q        <= RESET_PC_TAG;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            alu_sel_q   <= alu_sel_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            pc_q        <= pc_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.ex_op1     = op1_q;
    assign bus.ex_op2     = op2_q;
    assign bus.ex_alu_sel = alu_sel_q;
    assign bus.ex_rd      = rd_q;
    assign bus.ex_we      = we_q;
    assign bus.ex_pc      = out_valid_q ? pc_q : RESET_PC_TAG;
    assign bus.ex_illegal = illegal_q;

endmodule
